// File: rtl/scan_shift_engine.sv
// scan_shift_engine: one request = capture, serial shift and latch
// of a single slot in the scanchain.
module scan_shift_engine #(
  parameter int NUM_DESIGNS      = 5,
  parameter int NUM_IOS          = 8,
  parameter int SCAN_HALF_PERIOD = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [8:0]         active_select,
  input  logic [NUM_IOS-1:0] inputs,
  output logic [NUM_IOS-1:0] outputs,
  output logic               ready,
  output logic               err,
  output logic               busy,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select,
  output logic               scan_latch_en,
  input  logic               scan_clk_in,
  input  logic               scan_data_in
);
  localparam int TOTAL = NUM_DESIGNS * NUM_IOS;
  localparam int BW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW =
    (SCAN_HALF_PERIOD > 1) ? $clog2(SCAN_HALF_PERIOD) : 1;
  localparam int IW = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SCAN_HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               half_q, half_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [8:0]         sel_q, sel_d;
  logic [NUM_IOS-1:0] in_q, in_d;
  logic [NUM_IOS-1:0] cap_q, cap_d;
  logic [NUM_IOS-1:0] out_q, out_d;
  logic               err_q, err_d;

  logic               period_end;
  logic               rx_strobe;
  logic               hit;
  logic [31:0]        base_w;
  logic [31:0]        off_w;
  logic [IW-1:0]      bidx;
  logic               unused_clk_in;

  assign unused_clk_in = scan_clk_in;
  assign outputs = out_q;

  // Target bit b is on the wire at shift index TOTAL-1-k*NUM_IOS-b.
  always_comb begin
    base_w = 32'(TOTAL - 1) - 32'(sel_q) * 32'(NUM_IOS);
    off_w  = base_w - 32'(bit_q);
    hit    = (state_q == S_SHIFT)
           && (32'(bit_q) <= base_w)
           && (off_w < 32'(NUM_IOS));
    bidx   = off_w[IW-1:0];
  end

  assign period_end = half_q && (phase_q == PH_LAST);
  assign rx_strobe  = hit && !half_q && (phase_q == PH_LAST);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    half_d        = half_q;
    bit_d         = bit_q;
    sel_d         = sel_q;
    in_d          = in_q;
    cap_d         = cap_q;
    out_d         = out_q;
    err_d         = err_q;
    busy          = (state_q != S_IDLE);
    ready         = 1'b0;
    err           = 1'b0;
    scan_clk_out  = 1'b0;
    scan_data_out = 1'b0;
    scan_select   = 1'b0;
    scan_latch_en = 1'b0;

    if (state_q inside {S_CAPTURE, S_SHIFT, S_LATCH}) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        half_d  = !half_q;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end

    if (rx_strobe) cap_d[bidx] = scan_data_in;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = active_select;
          in_d    = inputs;
          phase_d = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          if (32'(active_select) >= 32'(NUM_DESIGNS)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        scan_select  = 1'b1;
        scan_clk_out = half_q;
        if (period_end) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        scan_clk_out  = half_q;
        scan_data_out = hit && in_q[bidx];
        if (period_end) begin
          if (bit_q == BIT_LAST) state_d = S_LATCH;
          else bit_d = bit_q + BW'(1);
        end
      end
      S_LATCH: begin
        scan_latch_en = 1'b1;
        if (period_end) begin
          state_d = S_DONE;
          out_d   = cap_q;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      sel_q   <= '0;
      in_q    <= '0;
      cap_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      in_q    <= in_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_scan_shift_engine.sv
// tb_scan_shift_engine: random passes through a behavioural
// scanchain, checked against slot-level expectations.
`timescale 1ns/1ps
module tb_scan_shift_engine;
  localparam int ND  = 5;
  localparam int NI  = 8;
  localparam int HP  = 2;
  localparam int TOT = ND * NI;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic          start = 1'b0;
  logic [8:0]    sel = '0;
  logic [NI-1:0] in_w = '0;
  logic [NI-1:0] out_w;
  logic ready, err, busy, sclk, sdo, ssel, slat, sdi;

  scan_shift_engine #(
    .NUM_DESIGNS(ND), .NUM_IOS(NI), .SCAN_HALF_PERIOD(HP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .active_select(sel), .inputs(in_w), .outputs(out_w),
    .ready(ready), .err(err), .busy(busy),
    .scan_clk_out(sclk), .scan_data_out(sdo),
    .scan_select(ssel), .scan_latch_en(slat),
    .scan_clk_in(sclk), .scan_data_in(sdi)
  );

  logic          start2 = 1'b0;
  logic [8:0]    sel2 = '0;
  logic [7:0]    in2 = '0;
  logic [7:0]    out2;
  logic ready2, err2, busy2, sclk2, sdo2, ssel2, slat2, sdi2;

  scan_shift_engine #(
    .NUM_DESIGNS(1), .NUM_IOS(8), .SCAN_HALF_PERIOD(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .active_select(sel2), .inputs(in2), .outputs(out2),
    .ready(ready2), .err(err2), .busy(busy2),
    .scan_clk_out(sclk2), .scan_data_out(sdo2),
    .scan_select(ssel2), .scan_latch_en(slat2),
    .scan_clk_in(sclk2), .scan_data_in(sdi2)
  );

  // Chain: position 0 at the head, design k bit b at k*NI+b.
  logic [TOT-1:0] chain = '0;
  logic [TOT-1:0] mod_in = '0;
  logic [NI-1:0]  mod_out [ND];
  int clk_edges = 0;
  int latch_edges = 0;
  int overlap = 0;

  assign sdi = chain[TOT-1];

  always @(posedge sclk) begin
    clk_edges++;
    if (ssel)
      for (int k = 0; k < ND; k++) chain[k*NI +: NI] <= mod_out[k];
    else
      chain <= {chain[TOT-2:0], sdo};
  end

  always @(posedge slat) begin
    latch_edges++;
    mod_in <= chain;
  end

  logic [7:0] chain2 = '0;
  logic [7:0] mod_in2 = '0;
  logic [7:0] mod_out2 = '0;
  int  edges2 = 0;
  time last2 = 0;
  time pmin = 1000;
  time pmax = 0;

  assign sdi2 = chain2[7];

  always @(posedge sclk2) begin
    edges2++;
    if (last2 != 0) begin
      if ($time - last2 < pmin) pmin = $time - last2;
      if ($time - last2 > pmax) pmax = $time - last2;
    end
    last2 = $time;
    chain2 <= ssel2 ? mod_out2 : {chain2[6:0], sdo2};
  end

  always @(posedge slat2) mod_in2 <= chain2;

  always @(negedge clk) begin
    if (ssel && slat) overlap++;
    if (ssel2 && slat2) overlap++;
  end

  logic [NI-1:0]  exp_out = '0;
  logic [TOT-1:0] exp_in = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_slots();
    for (int k = 0; k < ND; k++) mod_out[k] = NI'($urandom);
  endtask

  task automatic run_pass(input logic [8:0] s, input logic [NI-1:0] w,
                          input bit pulses);
    int n, bad, e0, exp_lat;
    bit seen, is_err;
    is_err  = int'(s) >= ND;
    exp_lat = is_err ? 1 : 2 * HP * (TOT + 2) + 1;
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    in_w  = w;
    e0    = clk_edges;
    n     = 0;
    bad   = 0;
    seen  = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      start = pulses && (n == 50 || n == 168 || n == 169);
      sel   = 9'($urandom);
      in_w  = NI'($urandom);
      if (ready) seen = 1'b1;
      else if (!busy || err) bad++;
    end
    if (!is_err) begin
      exp_out = mod_out[s];
      exp_in = '0;
      exp_in[s*NI +: NI] = w;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("done_flags", {61'b0, busy, err, ready},
          {61'b0, 1'b1, is_err, 1'b1});
    check("busy_window", 64'(bad), 64'(0));
    check("outputs", 64'(out_w), 64'(exp_out));
    check("slots", 64'(mod_in), 64'(exp_in));
    check("scan_edges", 64'(clk_edges - e0),
          64'(is_err ? 0 : TOT + 1));
  endtask

  initial begin
    int l0, n, e0;
    bit seen;
    logic [7:0] w2;

    repeat (3) @(negedge clk);
    check("reset_state",
          {out_w, ready, err, busy, sclk, sdo, ssel, slat}, '0);
    check("reset_state2",
          {out2, ready2, err2, busy2, sclk2, sdo2, ssel2, slat2}, '0);
    reset_n = 1'b1;

    randomize_slots();
    mod_out[2] = 8'hA5;
    run_pass(9'd2, 8'h3C, 1'b0);

    randomize_slots();
    run_pass(9'd0, 8'h81, 1'b0);
    randomize_slots();
    run_pass(9'd4, 8'h7E, 1'b0);

    for (int i = 0; i < 4; i++) begin
      randomize_slots();
      run_pass(9'($urandom_range(ND - 1, 0)), NI'($urandom), 1'b0);
    end

    run_pass(9'd5, NI'($urandom), 1'b0);
    run_pass(9'h1FF, NI'($urandom), 1'b0);
    run_pass(9'($urandom_range(511, ND)), NI'($urandom), 1'b0);

    randomize_slots();
    run_pass(9'd1, NI'($urandom), 1'b1);
    randomize_slots();
    run_pass(9'd3, NI'($urandom), 1'b0);

    // Abort a pass while bit 17 is on the wire.
    randomize_slots();
    @(negedge clk);
    start = 1'b1;
    sel   = 9'd3;
    in_w  = 8'h5A;
    repeat (75) begin
      @(negedge clk);
      start = 1'b0;
    end
    l0 = latch_edges;
    reset_n = 1'b0;
    #1;
    check("async_reset",
          {out_w, ready, err, busy, sclk, sdo, ssel, slat}, '0);
    exp_out = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_latch_on_abort", 64'(latch_edges - l0), 64'(0));
    check("idle_after_reset", {63'b0, busy}, 64'(0));
    randomize_slots();
    run_pass(9'($urandom_range(ND - 1, 0)), NI'($urandom), 1'b0);

    mod_out2 = 8'($urandom);
    w2 = 8'($urandom);
    @(negedge clk);
    start2 = 1'b1;
    sel2   = '0;
    in2    = w2;
    e0     = edges2;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      start2 = 1'b0;
      in2    = 8'($urandom);
      if (ready2) seen = 1'b1;
    end
    check("small_latency", 64'(n), 64'(21));
    check("small_err", {63'b0, err2}, 64'(0));
    check("small_outputs", 64'(out2), 64'(mod_out2));
    check("small_slot", 64'(mod_in2), 64'(w2));
    check("small_edges", 64'(edges2 - e0), 64'(9));
    check("small_period_min", 64'(pmin), 64'(20));
    check("small_period_max", 64'(pmax), 64'(20));

    check("select_latch_overlap", 64'(overlap), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
